// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-port RAM sequencing controller.
package ram_ctrl_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;

    localparam logic PORT_A   = 1'b0;
    localparam logic PORT_B   = 1'b1;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_ACK   = 3'd4,
        S_CLEAR = 3'd5
    } state_e;

endpackage

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin pick: on a tie the port that was not granted last wins.
module ram_rr_arbiter
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Single requester wins outright; a tie goes to the port not granted last.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_A;
        if (&req) begin
            gnt_id = ~last_grant;
        end else if (req[PORT_B]) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Sequences single RAM accesses for ports A and B and whole-array clears.
// All RAM-facing and client-facing outputs are registered from the next state.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    input  logic              clr_i,
    output logic              clr_ack_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_sel_o,
    output logic              ram_rw_o,
    output logic              ram_rst_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    // The read state drives the address on its first cycle and samples
    // RD_LAT cycles later, so it spans counter values 0..RD_LAT.
    localparam logic [1:0] RD_LAST = 2'(RD_LAT);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   ram_sel_q, ram_sel_d;
    logic                ram_rw_q, ram_rw_d;
    logic                ram_rst_q, ram_rst_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic                clr_ack_q, clr_ack_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                gnt_valid;
    logic                gnt_id;

    ram_rr_arbiter u_rr (
        .req        ({b_req_i, a_req_i}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Next-state, transaction latch and registered-output decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE: begin
                // The IDLE cycle carrying clr_ack ignores clr_i so a held
                // clear request cannot trigger a second clear.
                if (clr_i && !clr_ack_q) begin
                    state_d = S_CLEAR;
                end else if (gnt_valid) begin
                    port_d       = gnt_id;
                    last_grant_d = gnt_id;
                    we_d         = (gnt_id == PORT_B) ? b_we_i    : a_we_i;
                    addr_d       = (gnt_id == PORT_B) ? b_addr_i  : a_addr_i;
                    wdata_d      = (gnt_id == PORT_B) ? b_wdata_i : a_wdata_i;
                    cnt_d        = '0;
                    state_d      = (we_d == RW_WRITE) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = S_ACK;
            S_READ: begin
                if (cnt_q == RD_LAST) begin
                    if (port_q == PORT_B) b_rdata_d = ram_data_i;
                    else                  a_rdata_d = ram_data_i;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ram_rw_d   = (state_d == S_WRITE);
        ram_sel_d  = (state_d == S_WRITE || state_d == S_READ) ? addr_d : ram_sel_q;
        ram_data_d = (state_d == S_WRITE) ? wdata_d : '0;
        ram_rst_d  = (state_d == S_CLEAR) || (state_d == S_INIT);
        a_ack_d    = (state_d == S_ACK) && (port_q == PORT_A);
        b_ack_d    = (state_d == S_ACK) && (port_q == PORT_B);
        clr_ack_d  = (state_q == S_CLEAR);
        busy_d     = (state_d != S_IDLE);
    end

    // FSM state and registered outputs; reset parks in INIT with the RAM clear strobe up.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_INIT;
            last_grant_q <= PORT_B;
            cnt_q        <= '0;
            ram_sel_q    <= '0;
            ram_rw_q     <= 1'b0;
            ram_rst_q    <= 1'b1;
            ram_data_q   <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            clr_ack_q    <= 1'b0;
            busy_q       <= 1'b1;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ram_sel_q    <= ram_sel_d;
            ram_rw_q     <= ram_rw_d;
            ram_rst_q    <= ram_rst_d;
            ram_data_q   <= ram_data_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            clr_ack_q    <= clr_ack_d;
            busy_q       <= busy_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Latched transaction fields are only consumed after a grant, so no reset.
    always_ff @(posedge clk) begin
        port_q  <= port_d;
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign a_ack_o    = a_ack_q;
    assign b_ack_o    = b_ack_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
    assign clr_ack_o  = clr_ack_q;
    // busy_q resets high so INIT reads busy; gating with rst_ni keeps it low while reset is held.
    assign busy_o     = busy_q & rst_ni;
    assign ram_sel_o  = ram_sel_q;
    assign ram_rw_o   = ram_rw_q;
    assign ram_rst_o  = ram_rst_q;
    assign ram_data_o = ram_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM models, vector table, random traffic,
// alternation, clear and reset corner cases, plus an RD_LAT = 3 instance.
module tb_ram_port_arbiter;

    logic       clk, rst_n;
    logic       a_req, a_we, b_req, b_we, clr;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, clr_ack, busy, ram_rw, ram_rst;
    logic [3:0] a_rdata, b_rdata, ram_wd, ram_rd;
    logic [1:0] ram_sel;
    logic [3:0] mem [4];

    logic       a3_req, a3_we;
    logic [1:0] a3_addr;
    logic [3:0] a3_wdata;
    logic       a3_ack, b3_ack, clr_ack3, busy3, ram_rw3, ram_rst3;
    logic [3:0] a3_rdata, b3_rdata, ram_wd3, ram_rd3;
    logic [1:0] ram_sel3, d1, d2, d3;
    logic [3:0] mem3 [4];

    logic [3:0] model_mem [4];
    logic       last_port;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic       p;
        logic       we;
        logic [1:0] addr;
        logic [3:0] wd;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [10];

    ram_port_arbiter #(.RD_LAT(1)) dut (
        .clk(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rdata_o(b_rdata),
        .clr_i(clr), .clr_ack_o(clr_ack), .busy_o(busy),
        .ram_sel_o(ram_sel), .ram_rw_o(ram_rw), .ram_rst_o(ram_rst),
        .ram_data_o(ram_wd), .ram_data_i(ram_rd)
    );

    ram_port_arbiter #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_ni(rst_n),
        .a_req_i(a3_req), .a_we_i(a3_we), .a_addr_i(a3_addr), .a_wdata_i(a3_wdata),
        .a_ack_o(a3_ack), .a_rdata_o(a3_rdata),
        .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(2'd0), .b_wdata_i(4'd0),
        .b_ack_o(b3_ack), .b_rdata_o(b3_rdata),
        .clr_i(1'b0), .clr_ack_o(clr_ack3), .busy_o(busy3),
        .ram_sel_o(ram_sel3), .ram_rw_o(ram_rw3), .ram_rst_o(ram_rst3),
        .ram_data_o(ram_wd3), .ram_data_i(ram_rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency RAM for the RD_LAT = 1 instance.
    always @(posedge clk) begin
        if (ram_rst) for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
        else if (ram_rw) mem[ram_sel] <= ram_wd;
    end
    assign ram_rd = mem[ram_sel];

    // RAM whose read data follows the row select by three cycles.
    always @(posedge clk) begin
        d1 <= ram_sel3;
        d2 <= d1;
        d3 <= d2;
        if (ram_rst3) for (int i = 0; i < 4; i++) mem3[i] <= 4'h0;
        else if (ram_rw3) mem3[ram_sel3] <= ram_wd3;
    end
    assign ram_rd3 = mem3[d3];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_mem[i] = 4'h0;
    endtask

    // One transaction on the RD_LAT = 1 instance, starting from IDLE.
    task automatic txn(input logic p, input logic we, input logic [1:0] addr,
                       input logic [3:0] wd, input logic [3:0] exp_rd, input string name);
        int n, rw_cnt, other;
        bit got;
        if (p) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
        else   begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
        n = 0; rw_cnt = 0; other = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ram_rw) rw_cnt++;
            if (p ? a_ack : b_ack) other++;
            if (p ? b_ack : a_ack) got = 1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk({name, "_latency"}, n, we ? 2 : 3);
        chk({name, "_rw_cycles"}, rw_cnt, we ? 1 : 0);
        chk({name, "_other_ack"}, other, 0);
        if (!we) chk({name, "_rdata"}, p ? b_rdata : a_rdata, exp_rd);
        @(posedge clk); #1;
        chk({name, "_ack_single"}, p ? b_ack : a_ack, 0);
        chk({name, "_idle_busy"}, busy, 0);
        if (we) model_mem[addr] = wd;
        last_port = p;
    endtask

    // One transaction on port A of the RD_LAT = 3 instance.
    task automatic txn3(input logic we, input logic [1:0] addr, input logic [3:0] wd,
                        input logic [3:0] exp_rd, input string name);
        int n, rw_cnt, unstable;
        bit got;
        a3_we = we; a3_addr = addr; a3_wdata = wd; a3_req = 1'b1;
        n = 0; rw_cnt = 0; unstable = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ram_rw3) rw_cnt++;
            if (a3_ack) got = 1;
            else if (ram_sel3 != addr) unstable++;
        end
        a3_req = 1'b0;
        chk({name, "_latency"}, n, we ? 2 : 5);
        chk({name, "_rw_cycles"}, rw_cnt, we ? 1 : 0);
        chk({name, "_sel_stable"}, unstable, 0);
        if (!we) chk({name, "_rdata"}, a3_rdata, exp_rd);
        chk({name, "_quiet"}, int'(b3_ack) + int'(clr_ack3) + int'(b3_rdata != 4'h0), 0);
        @(posedge clk); #1;
        chk({name, "_idle_busy"}, busy3, 0);
    endtask

    initial begin
        int c, n, acks, last_c, rst_cnt, cack, cack_at;
        bit got;
        logic expp;
        logic p, we;
        logic [1:0] ad;
        logic [3:0] wd;

        rst_n = 1'b0; clr = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        a3_req = 0; a3_we = 0; a3_addr = 0; a3_wdata = 0;
        model_clear();
        last_port = 1'b1;

        tbl[0] = '{1'b0, 1'b1, 2'd2, 4'hA, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 2'd2, 4'h0, 4'hA};
        tbl[2] = '{1'b1, 1'b1, 2'd0, 4'h5, 4'h0};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'h5};
        tbl[4] = '{1'b0, 1'b1, 2'd3, 4'hF, 4'h0};
        tbl[5] = '{1'b1, 1'b0, 2'd3, 4'h0, 4'hF};
        tbl[6] = '{1'b0, 1'b0, 2'd1, 4'h0, 4'h0};
        tbl[7] = '{1'b1, 1'b1, 2'd1, 4'hC, 4'h0};
        tbl[8] = '{1'b0, 1'b0, 2'd1, 4'h0, 4'hC};
        tbl[9] = '{1'b1, 1'b0, 2'd2, 4'h0, 4'hA};

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_rst", ram_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_acks", int'(a_ack) + int'(b_ack) + int'(clr_ack), 0);
        chk("rst_rw_data_sel", int'(ram_rw) + int'(ram_wd) + int'(ram_sel), 0);
        chk("rst_rdata", int'(a_rdata) + int'(b_rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_ram_rst", ram_rst, 1);
        chk("init_busy", busy, 1);
        @(posedge clk); #1;
        chk("idle_ram_rst", ram_rst, 0);
        chk("idle_busy", busy, 0);

        // Table-driven single transactions.
        for (int i = 0; i < 10; i++)
            txn(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp, $sformatf("vec%0d", i));

        // Both ports hold write requests; grants must alternate every 3 cycles.
        a_we = 1; a_addr = 2'd0; a_wdata = 4'h3;
        b_we = 1; b_addr = 2'd1; b_wdata = 4'h4;
        a_req = 1; b_req = 1;
        expp = ~last_port; acks = 0; last_c = 0;
        for (c = 0; c < 40 && acks < 5; c++) begin
            @(posedge clk); #1;
            if (a_ack || b_ack) begin
                chk($sformatf("alt_port%0d", acks), int'(b_ack) + 2 * int'(a_ack), expp ? 1 : 2);
                if (acks > 0) chk($sformatf("alt_gap%0d", acks), c - last_c, 3);
                last_c = c;
                expp = ~expp;
                acks++;
            end
        end
        a_req = 0; b_req = 0;
        chk("alt_count", acks, 5);
        last_port = ~expp;
        model_mem[0] = 4'h3;
        model_mem[1] = 4'h4;
        @(posedge clk); #1;

        // Clear requested during a B read: read finishes, then one clear.
        b_we = 0; b_addr = 2'd0; b_req = 1;
        @(posedge clk); #1;
        clr = 1;
        n = 1; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (b_ack) got = 1;
        end
        b_req = 0;
        chk("clr_read_latency", n, 3);
        chk("clr_read_rdata", b_rdata, model_mem[0]);
        last_port = 1'b1;
        rst_cnt = 0; cack = 0; cack_at = -1;
        for (c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ram_rst) rst_cnt++;
            if (clr_ack) begin
                cack++;
                if (cack_at < 0) cack_at = c;
            end
            if (cack_at >= 0 && c == cack_at + 1) clr = 0;
        end
        clr = 0;
        chk("clr_rst_pulses", rst_cnt, 1);
        chk("clr_ack_pulses", cack, 1);
        chk("clr_ack_timing", cack_at, 3);
        model_clear();
        for (int r = 0; r < 4; r++)
            txn(r[0], 1'b0, 2'(r), 4'h0, 4'h0, $sformatf("cleared_row%0d", r));

        // Random single transactions against the array model.
        for (int i = 0; i < 30; i++) begin
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ad = 2'($urandom_range(0, 3));
            wd = 4'($urandom_range(0, 15));
            txn(p, we, ad, wd, model_mem[ad], $sformatf("rnd%0d", i));
        end

        // Reset pulsed during a WRITE: no ack, immediate reset outputs, INIT again.
        a_we = 1; a_addr = 2'd3; a_wdata = 4'h7; a_req = 1;
        @(posedge clk); #1;
        chk("rstw_in_write", ram_rw, 1);
        #2;
        rst_n = 1'b0;
        a_req = 0;
        #1;
        chk("rstw_ram_rst", ram_rst, 1);
        chk("rstw_rw", ram_rw, 0);
        chk("rstw_data", ram_wd, 0);
        chk("rstw_busy", busy, 0);
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            acks += int'(a_ack) + int'(b_ack);
        end
        chk("rstw_no_ack", acks, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstw_init_rst", ram_rst, 1);
        chk("rstw_init_busy", busy, 1);
        @(posedge clk); #1;
        chk("rstw_idle_rst", ram_rst, 0);
        model_clear();
        last_port = 1'b1;

        // After reset A wins the first tie.
        a_we = 0; a_addr = 2'd3; b_we = 0; b_addr = 2'd0;
        a_req = 1; b_req = 1;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (a_ack || b_ack) begin
                got = 1;
                chk("tie_first_is_a", int'(a_ack) + 2 * int'(b_ack), 1);
            end
        end
        a_req = 0; b_req = 0;
        chk("tie_latency", n, 3);
        chk("tie_rdata_cleared", a_rdata, 0);
        @(posedge clk); #1;

        // RD_LAT = 3 instance.
        txn3(1'b1, 2'd3, 4'h9, 4'h0, "lat3_wr3");
        txn3(1'b1, 2'd0, 4'h1, 4'h0, "lat3_wr0");
        txn3(1'b0, 2'd3, 4'h0, 4'h9, "lat3_rd3");
        txn3(1'b0, 2'd0, 4'h0, 4'h1, "lat3_rd0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
